// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter with an input FIFO.
//
// Bytes are accepted through a valid/ready handshake into a FIFO_DEPTH-entry
// FIFO and serialised one frame at a time: start bit, D data bits LSB first,
// optional parity bit, one or two stop bits. Frame configuration is sampled
// from cfg_* only at the moment a byte is popped and is held for that frame.
//
// Handshake: a byte is written on every rising clk edge where s_valid && s_ready.
// s_ready is a registered !full flag; it never depends on s_valid or on a pop
// in the same cycle, so a full FIFO refuses data even while it is draining.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   s_data/s_valid     byte to enqueue and its valid strobe
//   s_ready            FIFO not full
//   cfg_div            clk cycles per bit (0 and 1 behave as 2)
//   cfg_data_bits      0..3 -> 5..8 data bits
//   cfg_parity         0x none, 10 even, 11 odd
//   cfg_stop2          0 -> 1 stop bit, 1 -> 2 stop bits
//   uart_tx_out        serial line, idles high
//   tx_busy            frame on the line
//   tx_done            one-cycle pulse on the final cycle of each frame
//   fifo_level         bytes held in the FIFO
//   dbg_state          current FSM state (debug visibility)
module uart_tx_cfg #(
  parameter int CLK_DIV_W  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CLK_DIV_W-1:0] cfg_div,
  input  logic [1:0]           cfg_data_bits,
  input  logic [1:0]           cfg_parity,
  input  logic                 cfg_stop2,
  output logic                 uart_tx_out,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [LVL_W-1:0]     fifo_level,
  output logic [2:0]           dbg_state
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  // ---------------------------------------------------------------- FIFO
  logic [7:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0] count_q, count_d;
  logic             ready_q, ready_d;
  logic             push, pop;
  logic             fifo_empty;
  logic [7:0]       head;

  assign push       = s_valid && ready_q;
  assign fifo_empty = (count_q == '0);
  assign head       = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + LVL_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - LVL_W'(1);
    end
    ready_d = (count_d != LVL_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      ready_q <= ready_d;
    end
  end

  // Storage needs no reset: the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s_data;
  end

  // ------------------------------------------------- frame configuration
  // Values derived from the live cfg_* inputs; captured only when popping.
  logic [CLK_DIV_W-1:0] cfg_div_m1;
  logic [2:0]           cfg_dlast;
  logic [7:0]           cfg_mask;
  logic                 cfg_par_bit;

  always_comb begin
    cfg_div_m1  = (cfg_div < CLK_DIV_W'(2)) ? CLK_DIV_W'(1) : cfg_div - CLK_DIV_W'(1);
    cfg_dlast   = {1'b1, cfg_data_bits};             // index of last data bit (4..7)
    cfg_mask    = 8'hFF >> (2'd3 - cfg_data_bits);   // keeps only bits [D-1:0]
    cfg_par_bit = (^(head & cfg_mask)) ^ cfg_parity[0];
  end

  // ----------------------------------------------------------------- FSM
  state_e               state_q, state_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [CLK_DIV_W-1:0] timer_q, timer_d;
  logic [CLK_DIV_W-1:0] div_m1_q, div_m1_d;
  logic [2:0]           bit_cnt_q, bit_cnt_d;
  logic [2:0]           dlast_q, dlast_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 par_en_q, par_en_d;
  logic                 par_bit_q, par_bit_d;
  logic                 stop2_q, stop2_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 timer_zero, last_stop, load;

  assign timer_zero = (timer_q == '0);
  assign last_stop  = (stop_cnt_q == stop2_q);

  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timer_d    = timer_q;
    div_m1_d   = div_m1_q;
    bit_cnt_d  = bit_cnt_q;
    dlast_d    = dlast_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
    stop2_d    = stop2_q;
    stop_cnt_d = stop_cnt_q;
    load       = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (!fifo_empty) load = 1'b1;
      end
      S_START: begin
        if (timer_zero) begin
          state_d   = S_DATA;
          tx_d      = shreg_q[0];
          timer_d   = div_m1_q;
          bit_cnt_d = 3'd0;
        end else begin
          timer_d = timer_q - CLK_DIV_W'(1);
        end
      end
      S_DATA: begin
        if (timer_zero) begin
          timer_d = div_m1_q;
          if (bit_cnt_q == dlast_q) begin
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else begin
              state_d    = S_STOP;
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shreg_d   = {1'b0, shreg_q[7:1]};
            tx_d      = shreg_q[1];
          end
        end else begin
          timer_d = timer_q - CLK_DIV_W'(1);
        end
      end
      S_PARITY: begin
        if (timer_zero) begin
          state_d    = S_STOP;
          tx_d       = 1'b1;
          timer_d    = div_m1_q;
          stop_cnt_d = 1'b0;
        end else begin
          timer_d = timer_q - CLK_DIV_W'(1);
        end
      end
      S_STOP: begin
        if (timer_zero) begin
          if (!last_stop) begin
            stop_cnt_d = 1'b1;
            timer_d    = div_m1_q;
          end else if (!fifo_empty) begin
            load = 1'b1;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            tx_d    = 1'b1;
          end
        end else begin
          timer_d = timer_q - CLK_DIV_W'(1);
          // Raise done so it is visible during the final cycle (timer == 0).
          if (last_stop && (timer_q == CLK_DIV_W'(1))) done_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    // Pop a byte and start a frame with the configuration present right now.
    if (load) begin
      state_d   = S_START;
      tx_d      = 1'b0;
      busy_d    = 1'b1;
      timer_d   = cfg_div_m1;
      div_m1_d  = cfg_div_m1;
      dlast_d   = cfg_dlast;
      shreg_d   = head;
      par_en_d  = cfg_parity[1];
      par_bit_d = cfg_par_bit;
      stop2_d   = cfg_stop2;
    end
  end

  assign pop = load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timer_q    <= '0;
      div_m1_q   <= '0;
      bit_cnt_q  <= '0;
      dlast_q    <= '0;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      stop2_q    <= 1'b0;
      stop_cnt_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timer_q    <= timer_d;
      div_m1_q   <= div_m1_d;
      bit_cnt_q  <= bit_cnt_d;
      dlast_q    <= dlast_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
      stop2_q    <= stop2_d;
      stop_cnt_q <= stop_cnt_d;
    end
  end

  assign s_ready     = ready_q;
  assign uart_tx_out = tx_q;
  assign tx_busy     = busy_q;
  assign tx_done     = done_q;
  assign fifo_level  = count_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed testbench for uart_tx_cfg. Line bits are recorded per bit period
// into a vector (bit 0 = start bit, then data LSB first, parity, stops) and
// compared against hand-computed frame images.
module tb_uart_tx_cfg;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] cfg_div;
  logic [1:0]  cfg_data_bits;
  logic [1:0]  cfg_parity;
  logic        cfg_stop2;
  logic        uart_tx_out;
  logic        tx_busy;
  logic        tx_done;
  logic [2:0]  fifo_level;
  logic [2:0]  dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  uart_tx_cfg #(.CLK_DIV_W(16), .FIFO_DEPTH(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .s_data        (s_data),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .cfg_div       (cfg_div),
    .cfg_data_bits (cfg_data_bits),
    .cfg_parity    (cfg_parity),
    .cfg_stop2     (cfg_stop2),
    .uart_tx_out   (uart_tx_out),
    .tx_busy       (tx_busy),
    .tx_done       (tx_done),
    .fifo_level    (fifo_level),
    .dbg_state     (dbg_state)
  );

  // ------------------------------------------------ clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // ------------------------------------------------------ driver tasks
  task automatic set_cfg(input int div, input logic [1:0] db, input logic [1:0] par,
                         input logic st2);
    cfg_div       = 16'(div);
    cfg_data_bits = db;
    cfg_parity    = par;
    cfg_stop2     = st2;
  endtask

  // One-cycle push; caller guarantees the FIFO has room.
  task automatic push_one(input logic [7:0] d);
    s_data  = d;
    s_valid = 1'b1;
    @(posedge clk);
    #1 s_valid = 1'b0;
  endtask

  // Records nbits bit periods starting with the next falling edge.
  task automatic capture(input int eff, input int nbits, output logic [15:0] bits,
                         output int done_cnt, output int done_pos,
                         output int busy_low, output int glitch);
    bits = '0; done_cnt = 0; done_pos = -1; busy_low = 0; glitch = 0;
    for (int c = 0; c < eff * nbits; c++) begin
      @(negedge clk);
      if (c % eff == 0) bits[c / eff] = uart_tx_out;
      else if (uart_tx_out !== bits[c / eff]) glitch++;
      if (tx_done === 1'b1) begin done_cnt++; done_pos = c; end
      if (tx_busy !== 1'b1) busy_low++;
    end
  endtask

  // ------------------------------------------------------------- tests
  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b0; s_data = 8'h00;
    set_cfg(4, 2'd3, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({uart_tx_out, tx_busy, tx_done, s_ready} !== 4'b1001) begin
      errors++;
      $display("FAIL reset_outputs got tx/busy/done/ready=%b exp 1001",
               {uart_tx_out, tx_busy, tx_done, s_ready});
    end
    checks++;
    if (fifo_level !== 3'd0) begin
      errors++; $display("FAIL reset_level got %0d exp 0", fifo_level);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_8n1();
    logic [15:0] bits; int dc, dp, bl, gl;
    set_cfg(4, 2'd3, 2'b00, 1'b0);
    push_one(8'h55);
    checks++;
    if ({uart_tx_out, tx_busy, fifo_level} !== {1'b1, 1'b0, 3'd1}) begin
      errors++;
      $display("FAIL 8n1_after_push got tx=%b busy=%b lvl=%0d exp tx=1 busy=0 lvl=1",
               uart_tx_out, tx_busy, fifo_level);
    end
    @(posedge clk); #1;
    checks++;
    if ({uart_tx_out, tx_busy, fifo_level} !== {1'b0, 1'b1, 3'd0}) begin
      errors++;
      $display("FAIL 8n1_latency got tx=%b busy=%b lvl=%0d exp tx=0 busy=1 lvl=0",
               uart_tx_out, tx_busy, fifo_level);
    end
    capture(4, 10, bits, dc, dp, bl, gl);
    checks++;
    if (bits !== 16'h02AA) begin
      errors++; $display("FAIL 8n1_bits got %h exp 02aa", bits);
    end
    checks++;
    if (dc != 1 || dp != 39 || bl != 0 || gl != 0) begin
      errors++;
      $display("FAIL 8n1_timing got done_cnt=%0d pos=%0d busy_low=%0d glitch=%0d exp 1 39 0 0",
               dc, dp, bl, gl);
    end
    @(negedge clk);
    checks++;
    if ({uart_tx_out, tx_busy, tx_done} !== 3'b100) begin
      errors++;
      $display("FAIL 8n1_idle got tx/busy/done=%b exp 100", {uart_tx_out, tx_busy, tx_done});
    end
  endtask

  task automatic test_7e1_8o2();
    logic [15:0] bits; int dc, dp, bl, gl;
    set_cfg(3, 2'd2, 2'b10, 1'b0);
    s_data = 8'h41; s_valid = 1'b1;
    @(posedge clk);
    #1 s_data = 8'h07;
    @(posedge clk);           // pushes 0x07 while 0x41 is popped
    #1 s_valid = 1'b0;
    set_cfg(3, 2'd3, 2'b11, 1'b1);
    checks++;
    if (fifo_level !== 3'd1) begin
      errors++; $display("FAIL push_pop_level got %0d exp 1", fifo_level);
    end
    capture(3, 10, bits, dc, dp, bl, gl);
    checks++;
    if (bits !== 16'h0282) begin
      errors++; $display("FAIL 7e1_bits got %h exp 0282", bits);
    end
    checks++;
    if (dc != 1 || dp != 29 || bl != 0 || gl != 0) begin
      errors++;
      $display("FAIL 7e1_timing got done_cnt=%0d pos=%0d busy_low=%0d glitch=%0d exp 1 29 0 0",
               dc, dp, bl, gl);
    end
    capture(3, 12, bits, dc, dp, bl, gl);
    checks++;
    if (bits !== 16'h0C0E) begin
      errors++; $display("FAIL 8o2_bits got %h exp 0c0e", bits);
    end
    checks++;
    if (dc != 1 || dp != 35 || bl != 0 || gl != 0) begin
      errors++;
      $display("FAIL 8o2_timing got done_cnt=%0d pos=%0d busy_low=%0d glitch=%0d exp 1 35 0 0",
               dc, dp, bl, gl);
    end
    @(negedge clk);
    checks++;
    if ({uart_tx_out, tx_busy} !== 2'b10) begin
      errors++; $display("FAIL 8o2_idle got tx/busy=%b exp 10", {uart_tx_out, tx_busy});
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b6 [6];
    int acc [6];
    b6 = '{8'hA5, 8'h3C, 8'h01, 8'hFF, 8'h80, 8'h5A};
    set_cfg(2, 2'd3, 2'b00, 1'b0);
    @(posedge clk); #1;
    fork
      begin : driver
        for (int i = 0; i < 6; i++) begin
          logic r;
          int   n;
          s_data = b6[i]; s_valid = 1'b1;
          n = 0;
          do begin
            @(negedge clk) r = s_ready;
            @(posedge clk);
            n++;
          end while (!r && n < 100);
          #1 acc[i] = cyc;
          if (i == 4) begin
            checks++;
            if (fifo_level !== 3'd4 || s_ready !== 1'b0) begin
              errors++;
              $display("FAIL fifo_full got lvl=%0d ready=%b exp lvl=4 ready=0",
                       fifo_level, s_ready);
            end
          end
        end
        s_valid = 1'b0;
      end
      begin : monitor
        logic [15:0] bits; int dc, dp, bl, gl, k;
        k = 0;
        while (tx_busy !== 1'b1 && k < 20) begin @(posedge clk); #1; k++; end
        for (int f = 0; f < 6; f++) begin
          capture(2, 10, bits, dc, dp, bl, gl);
          checks++;
          if (bits !== ({7'd0, b6[f], 1'b0} | 16'h0200)) begin
            errors++;
            $display("FAIL b2b_bits frame %0d got %h exp %h", f, bits,
                     {7'd0, b6[f], 1'b0} | 16'h0200);
          end
          checks++;
          if (dc != 1 || dp != 19 || bl != 0 || gl != 0) begin
            errors++;
            $display("FAIL b2b_timing frame %0d got done_cnt=%0d pos=%0d busy_low=%0d glitch=%0d",
                     f, dc, dp, bl, gl);
          end
        end
      end
    join
    checks++;
    if (acc[4] - acc[0] != 4 || acc[5] - acc[4] != 18) begin
      errors++;
      $display("FAIL b2b_accept got gaps %0d %0d exp 4 18", acc[4] - acc[0], acc[5] - acc[4]);
    end
    @(negedge clk);
    checks++;
    if ({uart_tx_out, tx_busy, fifo_level} !== {1'b1, 1'b0, 3'd0}) begin
      errors++;
      $display("FAIL b2b_idle got tx=%b busy=%b lvl=%0d exp 1 0 0",
               uart_tx_out, tx_busy, fifo_level);
    end
  endtask

  task automatic test_small_div();
    logic [15:0] bits; int dc, dp, bl, gl;
    for (int d = 0; d < 2; d++) begin
      set_cfg(d, 2'd3, 2'b00, 1'b0);
      push_one(8'hC3);
      @(posedge clk); #1;
      capture(2, 10, bits, dc, dp, bl, gl);
      checks++;
      if (bits !== 16'h0386) begin
        errors++; $display("FAIL div%0d_bits got %h exp 0386", d, bits);
      end
      checks++;
      if (dc != 1 || dp != 19 || gl != 0) begin
        errors++;
        $display("FAIL div%0d_timing got done_cnt=%0d pos=%0d glitch=%0d exp 1 19 0",
                 d, dc, dp, gl);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cfg_midframe();
    logic [15:0] bits; int dc, dp, bl, gl;
    set_cfg(2, 2'd3, 2'b00, 1'b0);
    push_one(8'h96);
    @(posedge clk); #1;
    fork
      capture(2, 10, bits, dc, dp, bl, gl);
      begin
        repeat (7) @(posedge clk);
        #1 set_cfg(3, 2'd0, 2'b10, 1'b0);
        s_data = 8'hF3; s_valid = 1'b1;
        @(posedge clk);
        #1 s_valid = 1'b0;
      end
    join
    checks++;
    if (bits !== 16'h032C || dc != 1 || dp != 19) begin
      errors++;
      $display("FAIL mid_cur_frame got bits=%h done_cnt=%0d pos=%0d exp 032c 1 19", bits, dc, dp);
    end
    capture(3, 8, bits, dc, dp, bl, gl);
    checks++;
    if (bits !== 16'h00E6) begin
      errors++; $display("FAIL mid_next_bits got %h exp 00e6", bits);
    end
    checks++;
    if (dc != 1 || dp != 23 || bl != 0 || gl != 0) begin
      errors++;
      $display("FAIL mid_next_timing got done_cnt=%0d pos=%0d busy_low=%0d glitch=%0d exp 1 23 0 0",
               dc, dp, bl, gl);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [15:0] bits; int dc, dp, bl, gl, bad;
    set_cfg(4, 2'd3, 2'b00, 1'b0);
    s_data = 8'h11; s_valid = 1'b1;
    @(posedge clk); #1 s_data = 8'h22;
    @(posedge clk); #1 s_data = 8'h33;
    @(posedge clk); #1 s_valid = 1'b0;
    checks++;
    if (fifo_level !== 3'd2) begin
      errors++; $display("FAIL rst_queued got %0d exp 2", fifo_level);
    end
    repeat (10) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    #1;
    checks++;
    if ({uart_tx_out, tx_busy, tx_done, s_ready, fifo_level} !== {4'b1001, 3'd0}) begin
      errors++;
      $display("FAIL rst_async got tx/busy/done/ready=%b lvl=%0d exp 1001 0",
               {uart_tx_out, tx_busy, tx_done, s_ready}, fifo_level);
    end
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    bad = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (uart_tx_out !== 1'b1 || tx_busy !== 1'b0 || fifo_level !== 3'd0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL rst_quiet got %0d active cycles exp 0", bad);
    end
    push_one(8'h3C);
    @(posedge clk); #1;
    capture(4, 10, bits, dc, dp, bl, gl);
    checks++;
    if (bits !== 16'h0278 || dc != 1 || dp != 39) begin
      errors++;
      $display("FAIL rst_new_frame got bits=%h done_cnt=%0d pos=%0d exp 0278 1 39", bits, dc, dp);
    end
    @(negedge clk);
  endtask

  // -------------------------------------------------------- main / report
  initial begin
    test_reset();
    test_8n1();
    test_7e1_8o2();
    test_back_to_back();
    test_small_div();
    test_cfg_midframe();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
